// File: rtl/ym2203_bus_master.sv
// YM2203 register-bus initiator: address cycle, data/read cycle and chip wait times in CE ticks.
// Optional YM_BUSY_POLL_EN: FM-write recovery polls the status busy bit instead of counting FM_WAIT.
module ym2203_bus_master #(
  parameter int ADDR_WAIT = 17,
  parameter int FM_WAIT   = 83,
  parameter int PSG_WAIT  = 1,
  parameter int RD_LAT    = 2,
  parameter int CNT_W     = 7
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       CE,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_RD,
  input  logic [7:0] CMD_REG,
  input  logic [7:0] CMD_DATA,
  output logic       RD_VALID,
  output logic [7:0] RD_DATA,
  output logic       BUSY,
  output logic       YM_A0,
  output logic       YM_WE,
  output logic [7:0] YM_DO,
  input  logic [7:0] YM_DI
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AWAIT, S_DATA, S_DWAIT, S_READ, S_POLL} state_t;

  localparam logic [CNT_W-1:0] RDL = CNT_W'(RD_LAT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic             rd_q, rd_d;
  logic [7:0]       reg_q, reg_d, dat_q, dat_d;
  logic             a0_q, a0_d;
  logic [7:0]       do_q, do_d;
  logic             rdv_q, rdv_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rdy_en_q;
  logic             wait_done, fm;
  logic [CNT_W-1:0] cnt_dec;
`ifdef YM_BUSY_POLL_EN
  localparam int POLL_MAX = 255;
  logic [7:0] poll_q, poll_d;
`endif

  // Leave a wait state on the CE that consumes the last tick, or at once for a zero load.
  assign wait_done = (cnt_q == '0) || (CE && cnt_q == CNT_W'(1));
  assign cnt_dec   = cnt_q - {{(CNT_W-1){1'b0}}, CE};
  assign fm        = reg_q >= 8'h10;

  assign CMD_READY = rdy_en_q && state_q == S_IDLE;
  assign BUSY      = rdy_en_q && state_q != S_IDLE;
  // ph_q gives A0/DO one setup cycle before WE inside ADDR and DATA.
  assign YM_WE     = ph_q && (state_q == S_ADDR || state_q == S_DATA);
  assign YM_A0     = a0_q;
  assign YM_DO     = do_q;
  assign RD_VALID  = rdv_q;
  assign RD_DATA   = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    rd_d    = rd_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    a0_d    = a0_q;
    do_d    = do_q;
    rdv_d   = 1'b0;
    rdata_d = rdata_q;
`ifdef YM_BUSY_POLL_EN
    poll_d  = poll_q;
`endif
    case (state_q)
      S_IDLE: if (CMD_VALID && CMD_READY) begin
        rd_d    = CMD_RD;
        reg_d   = CMD_REG;
        dat_d   = CMD_DATA;
        a0_d    = 1'b0;
        do_d    = CMD_REG;
        ph_d    = 1'b0;
        state_d = S_ADDR;
      end
      S_ADDR: if (!ph_q) ph_d = 1'b1;
              else begin
                cnt_d   = CNT_W'(ADDR_WAIT);
                state_d = S_AWAIT;
              end
      S_AWAIT: if (wait_done) begin
        a0_d = 1'b1;
        if (rd_q) begin
          cnt_d   = RDL;
          state_d = S_READ;
        end else begin
          do_d    = dat_q;
          ph_d    = 1'b0;
          state_d = S_DATA;
        end
      end else cnt_d = cnt_dec;
      S_DATA: if (!ph_q) ph_d = 1'b1;
              else begin
`ifdef YM_BUSY_POLL_EN
                if (fm) begin
                  a0_d    = 1'b0;
                  cnt_d   = RDL;
                  poll_d  = '0;
                  state_d = S_POLL;
                end else begin
                  cnt_d   = CNT_W'(PSG_WAIT);
                  state_d = S_DWAIT;
                end
`else
                cnt_d   = fm ? CNT_W'(FM_WAIT) : CNT_W'(PSG_WAIT);
                state_d = S_DWAIT;
`endif
              end
      S_DWAIT: if (wait_done) state_d = S_IDLE;
               else cnt_d = cnt_dec;
      S_READ: if (cnt_q == '0) begin
        rdata_d = YM_DI;
        rdv_d   = 1'b1;
        state_d = S_IDLE;
      end else cnt_d = cnt_q - CNT_W'(1);
`ifdef YM_BUSY_POLL_EN
      S_POLL: begin
        poll_d = poll_q + 8'd1;
        if (poll_q == 8'(POLL_MAX - 1)) state_d = S_IDLE;
        else if (cnt_q == '0) begin
          if (YM_DI[7]) cnt_d = RDL;
          else state_d = S_IDLE;
        end else cnt_d = cnt_q - CNT_W'(1);
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ph_q     <= 1'b0;
      rd_q     <= 1'b0;
      reg_q    <= '0;
      dat_q    <= '0;
      a0_q     <= 1'b0;
      do_q     <= '0;
      rdv_q    <= 1'b0;
      rdata_q  <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      rd_q     <= rd_d;
      reg_q    <= reg_d;
      dat_q    <= dat_d;
      a0_q     <= a0_d;
      do_q     <= do_d;
      rdv_q    <= rdv_d;
      rdata_q  <= rdata_d;
      rdy_en_q <= 1'b1;
    end
  end

`ifdef YM_BUSY_POLL_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) poll_q <= '0;
    else          poll_q <= poll_d;
  end
`endif

endmodule
